// File: rtl/alarm_sequencer.sv
// Alarm-clock buzzer sequencer: arms, rings on a fresh time==alarm match, handles snooze/stop.
// Optional day-of-week gating of the trigger is enabled by defining ALARM_DAYMASK_EN.
module alarm_sequencer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 540,
    parameter int MAX_SNOOZE = 3,
    parameter int ND         = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_alarm_on,
    input  logic          i_match,
    input  logic [2:0]    i_tday,
    input  logic [ND-1:0] i_day_mask,
    input  logic          i_snooze_req,
    input  logic          i_stop_req,
    output logic          o_buzz,
    output logic [1:0]    o_state,
    output logic [1:0]    o_snooze_cnt,
    output logic [9:0]    o_timer
);
    // state   | meaning
    // IDLE    | alarm switched off
    // ARMED   | waiting for a fresh time==alarm match
    // RINGING | buzzer driven, ring timeout counting down
    // SNOOZE  | buzzer quiet, snooze interval counting down
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZE  = 2'b11
    } state_t;

    localparam logic [9:0] RING_LOAD   = 10'(RING_SEC - 1);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC - 1);
    localparam logic [1:0] CNT_MAX     = 2'(MAX_SNOOZE);

    state_t     r_state;
    logic [9:0] r_timer;
    logic [1:0] r_snooze_cnt;
    logic       r_match_d;
    logic       r_buzz;

    state_t     w_next_state;
    logic [9:0] w_next_timer;
    logic [1:0] w_next_cnt;
    logic       w_day_ok;
    logic       w_trig;

`ifdef ALARM_DAYMASK_EN
    // Out-of-range day numbers never allow a trigger.
    assign w_day_ok = (32'(i_tday) < ND) ? i_day_mask[i_tday] : 1'b0;
`else
    logic w_unused_day;
    assign w_unused_day = ^{i_tday, i_day_mask};
    assign w_day_ok     = 1'b1;
`endif

    assign w_trig = i_match & ~r_match_d & w_day_ok;

    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_cnt   = r_snooze_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_alarm_on) w_next_state = S_ARMED;
            end
            S_ARMED: begin
                if (!i_alarm_on) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (w_trig) begin
                    w_next_state = S_RINGING;
                    w_next_timer = RING_LOAD;
                    w_next_cnt   = '0;
                end
            end
            S_RINGING: begin
                if (!i_alarm_on) begin
                    w_next_state = S_IDLE;
                    w_next_timer = '0;
                    w_next_cnt   = '0;
                end else if (i_stop_req) begin
                    w_next_state = S_ARMED;
                    w_next_timer = '0;
                end else if (i_snooze_req && (r_snooze_cnt < CNT_MAX)) begin
                    w_next_state = S_SNOOZE;
                    w_next_timer = SNOOZE_LOAD;
                    w_next_cnt   = r_snooze_cnt + 2'd1;
                end else if (i_snooze_req || (r_timer == '0)) begin
                    // Snooze budget exhausted behaves as stop; timeout auto-silences.
                    w_next_state = S_ARMED;
                    w_next_timer = '0;
                end else begin
                    w_next_timer = r_timer - 10'd1;
                end
            end
            S_SNOOZE: begin
                if (!i_alarm_on) begin
                    w_next_state = S_IDLE;
                    w_next_timer = '0;
                    w_next_cnt   = '0;
                end else if (i_stop_req) begin
                    w_next_state = S_ARMED;
                    w_next_timer = '0;
                end else if (r_timer == '0) begin
                    w_next_state = S_RINGING;
                    w_next_timer = RING_LOAD;
                end else begin
                    w_next_timer = r_timer - 10'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_timer = '0;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_snooze_cnt <= '0;
            r_match_d    <= 1'b0;
            r_buzz       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_timer      <= w_next_timer;
            r_snooze_cnt <= w_next_cnt;
            r_match_d    <= i_match;
            r_buzz       <= (w_next_state == S_RINGING);
        end
    end

    assign o_buzz       = r_buzz;
    assign o_state      = r_state;
    assign o_snooze_cnt = r_snooze_cnt;
    assign o_timer      = r_timer;
endmodule
